multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control unit for the multicycle MIPS core. Sits upstream of the datapath:
//  decodes opcode/funct from the instruction register and, one state per cycle, drives
//  the mux selects, register enables and memory strobes the datapath consumes.
//  Also keeps a retired-instruction counter for bring-up and benches.
// PARAMETERS
//  CNT_W       32  width of instret counter
// PORTS
//  clk          in   1      clock; all state changes on posedge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      IR[31:26]
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag (combinational, same cycle)
//  pc_src       out  2      00 jump target, 01 ALU result, 10 ALUOut
//  alu_src_a    out  2      00 PC, 01 Reg_A, 10 shamt
//  alu_src_b    out  3      000 const 4, 001 Reg_B, 010 SignExtImm, 011 SignExtAddr, 100 ZeroExtImm
//  alu_ctl      out  4      0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 sll, 1001 srl
//  pc_write     out  1      PC register enable (branch-qualified)
//  ir_write     out  1      instruction register enable
//  alu_out_en   out  1      ALUOut register enable
//  mem_read_i   out  1      instruction memory read
//  mem_read     out  1      data memory read
//  mem_write    out  1      data memory write
//  reg_write    out  1      register file write enable
//  reg_dst      out  1      1 = rd, 0 = rt
//  mem_to_reg   out  1      1 = ALUOut, 0 = MDR
//  state        out  4      current state code (debug)
//  illegal_op   out  1      1-cycle pulse: unsupported opcode/funct decoded
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state=FETCH(0), instret=0, illegal_op=0; all enables/strobes forced 0 while reset=1;
//    selects 0. First fetch happens the cycle after reset deasserts. Reset mid-instruction aborts it, no retire.
//  - Outputs are Moore (decoded from state only), except pc_write in BRANCH (depends on zero).
//  - States/actions (unlisted outputs 0):
//    FETCH(0):  mem_read_i, ir_write, srcA=00, srcB=000, add, pc_src=01, pc_write -> DECODE
//    DECODE(1): srcA=00, srcB=011, add, alu_out_en -> by opcode:
//      0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x04/0x05 -> BRANCH; 0x02 -> JUMP;
//      0x08/0x0C/0x0D -> IEXEC; other -> FETCH with illegal_op pulse
//    MEMADR(2): srcA=01, srcB=010, add, alu_out_en -> MEMRD (lw) / MEMWR (sw)
//    MEMRD(3):  mem_read (MDR captures at edge) -> MEMWB
//    MEMWB(4):  reg_write, reg_dst=0, mem_to_reg=0 -> FETCH, retire
//    MEMWR(5):  mem_write -> FETCH, retire
//    EXEC(6):   srcA=01 (10 for sll/srl), srcB=001, alu_ctl per funct, alu_out_en -> RWB
//      funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll, 0x02 srl;
//      other funct -> FETCH with illegal_op pulse, no retire
//    RWB(7):    reg_write, reg_dst=1, mem_to_reg=1 -> FETCH, retire
//    BRANCH(8): srcA=01, srcB=001, sub, pc_src=10; pc_write = zero (beq) / ~zero (bne) -> FETCH, retire
//    JUMP(9):   pc_src=00, pc_write -> FETCH, retire
//    IEXEC(10): srcA=01, srcB=010 add (addi) / 100 and (andi) / 100 or (ori), alu_out_en -> IWB
//    IWB(11):   reg_write, reg_dst=0, mem_to_reg=1 -> FETCH, retire
//    codes 12-15: unreachable; treated as FETCH next cycle, no outputs asserted
//  - opcode/funct are sampled from IR, stable from DECODE onward (ir_write only in FETCH).
//  - CPI: lw 5, sw/R/imm 4, beq/bne/j 3.
//  - Retire: instret += 1 on the edge leaving a retiring state; wraps at 2^CNT_W-1 -> 0.
//  - illegal_op is high for exactly the cycle in which the illegal state is left.
// TESTING
//  1 reset held 3 cycles, release -> state 0,1 sequence; all enables 0 during reset; instret=0
//  2 opcode 0x00 funct 0x20 -> states 0,1,6,7,0; reg_write=1 reg_dst=1 mem_to_reg=1 only in RWB; instret=1
//  3 opcode 0x23 then 0x2B -> states 0,1,2,3,4 then 0,1,2,5; mem_write pulses 1 cycle; instret=2
//  4 opcode 0x04 with zero=1, then zero=0 -> pc_write=1 / 0 in BRANCH, pc_src=10; opcode 0x05 inverts
//  5 opcode 0x3F, then 0x00 funct 0x3F -> illegal_op 1-cycle pulse each, back to FETCH, instret unchanged
//  6 reset asserted in MEMRD -> next state FETCH, no reg_write, instret unchanged; CNT_W=4 wraps 15 -> 0

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control unit for the multicycle MIPS core. Decodes opcode/funct held in
//   the instruction register and, one state per cycle, drives the datapath mux
//   selects, register enables and memory strobes. Also counts retired instructions.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//     0   | FETCH  : read imem, load IR, PC <= PC + 4
//     1   | DECODE : branch target into ALUOut, dispatch on opcode
//     2   | MEMADR : effective address for lw/sw
//     3   | MEMRD  : data memory read (MDR captures)
//     4   | MEMWB  : MDR -> rt                                   (retires)
//     5   | MEMWR  : data memory write                           (retires)
//     6   | EXEC   : R-type ALU operation
//     7   | RWB    : ALUOut -> rd                                (retires)
//     8   | BRANCH : compare, conditional PC <= ALUOut           (retires)
//     9   | JUMP   : PC <= jump target                           (retires)
//    10   | IEXEC  : immediate ALU operation
//    11   | IWB    : ALUOut -> rt                                (retires)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_opcode, i_funct     IR[31:26], IR[5:0]
//   i_zero                ALU zero flag (same cycle)
//   o_pc_src, o_alu_src_a, o_alu_src_b, o_alu_ctl   datapath selects
//   o_pc_write .. o_mem_to_reg                       enables / strobes
//   o_state               current state code
//   o_illegal_op          pulse while leaving an illegal decode
//   o_instret             retired-instruction counter (wraps)

module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  output logic [1:0]       o_pc_src,
  output logic [1:0]       o_alu_src_a,
  output logic [2:0]       o_alu_src_b,
  output logic [3:0]       o_alu_ctl,
  output logic             o_pc_write,
  output logic             o_ir_write,
  output logic             o_alu_out_en,
  output logic             o_mem_read_i,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_reg_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic [3:0]       o_state,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  // br/bne mark the BRANCH state so pc_write can be qualified by the live zero flag.
  typedef struct packed {
    logic [1:0] pc_src;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [3:0] alu;
    logic       pc_write;
    logic       br;
    logic       bne;
    logic       ir_write;
    logic       alu_out_en;
    logic       mem_read_i;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctl_t;

  state_t           r_state;
  ctl_t             r_ctl;
  logic [CNT_W-1:0] r_instret;
  state_t           w_next;
  logic             w_op_legal;
  logic             w_funct_legal;
  logic             w_retire;

  function automatic ctl_t decode(state_t s, logic [5:0] op, logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read_i = 1'b1;
        c.ir_write   = 1'b1;
        c.alu        = ALU_ADD;
        c.pc_src     = 2'b01;
        c.pc_write   = 1'b1;
      end
      S_DECODE: begin
        c.src_b      = 3'b011;
        c.alu        = ALU_ADD;
        c.alu_out_en = 1'b1;
      end
      S_MEMADR: begin
        c.src_a      = 2'b01;
        c.src_b      = 3'b010;
        c.alu        = ALU_ADD;
        c.alu_out_en = 1'b1;
      end
      S_MEMRD: c.mem_read  = 1'b1;
      S_MEMWB: c.reg_write = 1'b1;
      S_MEMWR: c.mem_write = 1'b1;
      S_EXEC: begin
        // shifts take the shift amount on port A instead of Reg_A
        c.src_a      = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
        c.src_b      = 3'b001;
        c.alu_out_en = 1'b1;
        case (fn)
          6'h20:   c.alu = ALU_ADD;
          6'h22:   c.alu = ALU_SUB;
          6'h24:   c.alu = ALU_AND;
          6'h25:   c.alu = ALU_OR;
          6'h2A:   c.alu = ALU_SLT;
          6'h00:   c.alu = ALU_SLL;
          6'h02:   c.alu = ALU_SRL;
          default: c.alu = ALU_AND;
        endcase
      end
      S_RWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.src_a  = 2'b01;
        c.src_b  = 3'b001;
        c.alu    = ALU_SUB;
        c.pc_src = 2'b10;
        c.br     = 1'b1;
        c.bne    = (op == 6'h05);
      end
      S_JUMP: c.pc_write = 1'b1;
      S_IEXEC: begin
        c.src_a      = 2'b01;
        c.alu_out_en = 1'b1;
        case (op)
          6'h0C: begin c.src_b = 3'b100; c.alu = ALU_AND; end
          6'h0D: begin c.src_b = 3'b100; c.alu = ALU_OR;  end
          default: begin c.src_b = 3'b010; c.alu = ALU_ADD; end
        endcase
      end
      S_IWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_op_legal = 1'b0;
    case (i_opcode)
      6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D: w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_funct_legal = 1'b0;
    case (i_funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: w_funct_legal = 1'b1;
      default: w_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          6'h23, 6'h2B:        w_next = S_MEMADR;
          6'h00:               w_next = S_EXEC;
          6'h04, 6'h05:        w_next = S_BRANCH;
          6'h02:               w_next = S_JUMP;
          6'h08, 6'h0C, 6'h0D: w_next = S_IEXEC;
          default:             w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (i_opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = w_funct_legal ? S_RWB : S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWR) || (r_state == S_RWB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP) || (r_state == S_IWB);

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctl     <= decode(S_FETCH, i_opcode, i_funct);
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= decode(w_next, i_opcode, i_funct);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Everything except the debug state and the counter is held at zero during reset.
  assign o_pc_src     = reset ? 2'b00  : r_ctl.pc_src;
  assign o_alu_src_a  = reset ? 2'b00  : r_ctl.src_a;
  assign o_alu_src_b  = reset ? 3'b000 : r_ctl.src_b;
  assign o_alu_ctl    = reset ? 4'b0000 : r_ctl.alu;
  assign o_pc_write   = ~reset & (r_ctl.br ? (r_ctl.bne ? ~i_zero : i_zero) : r_ctl.pc_write);
  assign o_ir_write   = ~reset & r_ctl.ir_write;
  assign o_alu_out_en = ~reset & r_ctl.alu_out_en;
  assign o_mem_read_i = ~reset & r_ctl.mem_read_i;
  assign o_mem_read   = ~reset & r_ctl.mem_read;
  assign o_mem_write  = ~reset & r_ctl.mem_write;
  assign o_reg_write  = ~reset & r_ctl.reg_write;
  assign o_reg_dst    = ~reset & r_ctl.reg_dst;
  assign o_mem_to_reg = ~reset & r_ctl.mem_to_reg;
  assign o_state      = r_state;
  assign o_instret    = r_instret;
  assign o_illegal_op = ~reset & (((r_state == S_DECODE) & ~w_op_legal) |
                                  ((r_state == S_EXEC) & ~w_funct_legal));

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Directed instruction sequences for multicycle_control_fsm. The driver issues
//   one cycle at a time and queues the hand-derived expected outputs for that
//   cycle; a negedge monitor pops and compares. A second instance with CNT_W=4
//   shows the counter wrap.

module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;

  logic [1:0]  pc_src, alu_src_a;
  logic [2:0]  alu_src_b;
  logic [3:0]  alu_ctl, state;
  logic        pc_write, ir_write, alu_out_en, mem_read_i, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [31:0] instret;

  logic [1:0]  b_pc_src, b_alu_src_a;
  logic [2:0]  b_alu_src_b;
  logic [3:0]  b_alu_ctl, b_state;
  logic        b_pc_write, b_ir_write, b_alu_out_en, b_mem_read_i, b_mem_read, b_mem_write;
  logic        b_reg_write, b_reg_dst, b_mem_to_reg, b_illegal_op;
  logic [3:0]  b_instret;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .o_pc_src(pc_src), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_ctl(alu_ctl),
    .o_pc_write(pc_write), .o_ir_write(ir_write), .o_alu_out_en(alu_out_en),
    .o_mem_read_i(mem_read_i), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_reg_write(reg_write), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg),
    .o_state(state), .o_illegal_op(illegal_op), .o_instret(instret)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .o_pc_src(b_pc_src), .o_alu_src_a(b_alu_src_a), .o_alu_src_b(b_alu_src_b), .o_alu_ctl(b_alu_ctl),
    .o_pc_write(b_pc_write), .o_ir_write(b_ir_write), .o_alu_out_en(b_alu_out_en),
    .o_mem_read_i(b_mem_read_i), .o_mem_read(b_mem_read), .o_mem_write(b_mem_write),
    .o_reg_write(b_reg_write), .o_reg_dst(b_reg_dst), .o_mem_to_reg(b_mem_to_reg),
    .o_state(b_state), .o_illegal_op(b_illegal_op), .o_instret(b_instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctl;
    logic        ill;
    logic [31:0] ir;
    logic [3:0]  ir4;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_instret = 32'd0;

  wire [19:0] got_ctl = {pc_src, alu_src_a, alu_src_b, alu_ctl, pc_write, ir_write, alu_out_en,
                         mem_read_i, mem_read, mem_write, reg_write, reg_dst, mem_to_reg};

  // Expected control word per state, written out from the state/action table.
  function automatic logic [19:0] exp_ctl(int st, logic [5:0] op, logic [5:0] fn, logic z, logic rst);
    logic [1:0] ps, a;
    logic [2:0] b;
    logic [3:0] alu;
    logic pcw, irw, aoe, mri, mr, mw, rw, rd, m2r;
    ps = 2'b00; a = 2'b00; b = 3'b000; alu = 4'b0000;
    pcw = 0; irw = 0; aoe = 0; mri = 0; mr = 0; mw = 0; rw = 0; rd = 0; m2r = 0;
    if (!rst) begin
      case (st)
        0:  begin mri = 1; irw = 1; alu = 4'b0010; ps = 2'b01; pcw = 1; end
        1:  begin b = 3'b011; alu = 4'b0010; aoe = 1; end
        2:  begin a = 2'b01; b = 3'b010; alu = 4'b0010; aoe = 1; end
        3:  mr = 1;
        4:  rw = 1;
        5:  mw = 1;
        6:  begin
              a = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
              b = 3'b001; aoe = 1;
              case (fn)
                6'h20: alu = 4'b0010;
                6'h22: alu = 4'b0110;
                6'h24: alu = 4'b0000;
                6'h25: alu = 4'b0001;
                6'h2A: alu = 4'b0111;
                6'h00: alu = 4'b1000;
                6'h02: alu = 4'b1001;
                default: alu = 4'b0000;
              endcase
            end
        7:  begin rw = 1; rd = 1; m2r = 1; end
        8:  begin a = 2'b01; b = 3'b001; alu = 4'b0110; ps = 2'b10; pcw = (op == 6'h04) ? z : ~z; end
        9:  begin ps = 2'b00; pcw = 1; end
        10: begin
              a = 2'b01; aoe = 1;
              if (op == 6'h08)      begin b = 3'b010; alu = 4'b0010; end
              else if (op == 6'h0C) begin b = 3'b100; alu = 4'b0000; end
              else                  begin b = 3'b100; alu = 4'b0001; end
            end
        11: begin rw = 1; m2r = 1; end
        default: ;
      endcase
    end
    return {ps, a, b, alu, pcw, irw, aoe, mri, mr, mw, rw, rd, m2r};
  endfunction

  task automatic cyc(logic rst, int st, logic ill, logic [5:0] op, logic [5:0] fn, logic z);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; opcode = op; funct = fn; zero = z;
    e.st  = st[3:0];
    e.ctl = exp_ctl(st, op, fn, z, rst);
    e.ill = ill & ~rst;
    e.ir  = exp_instret;
    e.ir4 = exp_instret[3:0];
    q.push_back(e);
    if (rst) exp_instret = 32'd0;
    else if (st == 4 || st == 5 || st == 7 || st == 8 || st == 9 || st == 11)
      exp_instret = exp_instret + 32'd1;
  endtask

  // seq holds the expected state codes as nibbles, first state in the most significant used nibble.
  task automatic instr(logic [5:0] op, logic [5:0] fn, logic z, logic [23:0] seq, int n, int ill_at);
    for (int i = 0; i < n; i++) begin
      logic [3:0] s;
      s = seq[4*(n-1-i) +: 4];
      cyc(1'b0, int'(s), (i == ill_at), op, fn, z);
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state",      {28'd0, state},      {28'd0, e.st});
      chk("ctl",        {12'd0, got_ctl},    {12'd0, e.ctl});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
      chk("instret",    instret,             e.ir);
      chk("instret4",   {28'd0, b_instret},  {28'd0, e.ir4});
    end
  end

  initial begin
    // reset held 3 cycles
    repeat (3) cyc(1'b1, 0, 1'b0, 6'h00, 6'h20, 1'b0);
    // lw aborted by reset in MEMRD, held one more cycle
    instr(6'h23, 6'h00, 1'b0, 24'h000012, 3, -1);
    cyc(1'b1, 3, 1'b0, 6'h23, 6'h00, 1'b0);
    cyc(1'b1, 0, 1'b0, 6'h23, 6'h00, 1'b0);
    // R-type add
    instr(6'h00, 6'h20, 1'b0, 24'h000167, 4, -1);
    // lw then sw
    instr(6'h23, 6'h00, 1'b0, 24'h001234, 5, -1);
    instr(6'h2B, 6'h00, 1'b0, 24'h000125, 4, -1);
    // beq / bne with both zero values
    instr(6'h04, 6'h00, 1'b1, 24'h000018, 3, -1);
    instr(6'h04, 6'h00, 1'b0, 24'h000018, 3, -1);
    instr(6'h05, 6'h00, 1'b1, 24'h000018, 3, -1);
    instr(6'h05, 6'h00, 1'b0, 24'h000018, 3, -1);
    // remaining R-type functs, shifts use shamt on port A
    instr(6'h00, 6'h22, 1'b0, 24'h000167, 4, -1);
    instr(6'h00, 6'h24, 1'b0, 24'h000167, 4, -1);
    instr(6'h00, 6'h25, 1'b0, 24'h000167, 4, -1);
    instr(6'h00, 6'h2A, 1'b0, 24'h000167, 4, -1);
    instr(6'h00, 6'h00, 1'b0, 24'h000167, 4, -1);
    instr(6'h00, 6'h02, 1'b0, 24'h000167, 4, -1);
    // jump and immediates
    instr(6'h02, 6'h00, 1'b0, 24'h000019, 3, -1);
    instr(6'h08, 6'h00, 1'b0, 24'h0001AB, 4, -1);
    instr(6'h0C, 6'h00, 1'b0, 24'h0001AB, 4, -1);
    instr(6'h0D, 6'h00, 1'b0, 24'h0001AB, 4, -1);
    // illegal opcode, then illegal funct
    instr(6'h3F, 6'h00, 1'b0, 24'h000001, 2, 1);
    instr(6'h00, 6'h3F, 1'b0, 24'h000016, 3, 2);
    // run jumps until the 4-bit counter wraps at least once
    repeat (20) instr(6'h02, 6'h00, 1'b0, 24'h000019, 3, -1);
    cyc(1'b0, 0, 1'b0, 6'h00, 6'h20, 1'b0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
